// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the divider front-end stage.
//   state_t             - stage FSM state encoding
//   ZERO_RESULT_DEFAULT - quotient returned when the divisor is zero
//   INT_MIN             - most negative 32-bit two's-complement value
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [31:0] ZERO_RESULT_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN             = 32'h8000_0000;

endpackage

// File: rtl/div_stage_lzc32.sv
// lzc32: combinational 32-bit leading-zero counter.
//   value - word to scan
//   count - number of leading zeros, 0..32 (32 means value == 0)
module lzc32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Scan from LSB upward so the highest set bit is the last one to write
  // the count; an all-zero word falls through to 32.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) begin
        count = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/div_stage.sv
// div_stage: request/response front-end for the 32-bit unsigned iterative
// divider. Converts signed/unsigned operands to magnitudes, handles the
// operand classes the divider cannot finish (b == 0, dividend >= 2^31,
// divisor >= 2^31) locally, and applies sign correction and flags.
//   clk, reset        - clock, asynchronous active-low reset
//   req_*             - request channel (valid/ready, a, b, signed)
//   rsp_*             - response channel (valid/ready, quotient, flags)
//   div_a/div_b/div_go       - operands and start pulse to the divider
//   div_c/div_available      - quotient and done pulse from the divider
module div_stage
  import div_pkg::*;
#(
  parameter logic [31:0] ZERO_RESULT = ZERO_RESULT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_q,
  output logic        rsp_is_zero,
  output logic        rsp_is_negative,
  output logic        rsp_div_zero,
  output logic        rsp_overflow,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_go,
  input  logic [31:0] div_c,
  input  logic        div_available
);

  state_t      state;
  logic        neg_a, neg_b, ovf;
  logic [31:0] mag_a, mag_b, q_hi, q_mag;

  logic        in_neg_a, in_neg_b;
  logic [5:0]  lz;
  logic [4:0]  k;
  logic [31:0] t_full, t_half, q_hi_full, q_hi_half, fix_q;

  assign in_neg_a = req_signed & req_a[31];
  assign in_neg_b = req_signed & req_b[31];

  lzc32 u_lzc (
    .value (mag_b),
    .count (lz)
  );

  // Split path for a dividend with bit 31 set: subtract the divisor aligned
  // to bit 31 (or one position lower if that is too big) so the residue the
  // divider sees is below 2^31, and keep the matching quotient bit aside.
  assign k         = lz[4:0];
  assign t_full    = mag_b << k;
  assign t_half    = t_full >> 1;
  assign q_hi_full = 32'd1 << k;
  assign q_hi_half = q_hi_full >> 1;

  assign fix_q = ovf ? INT_MIN : ((neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_q           <= '0;
      rsp_is_zero     <= 1'b0;
      rsp_is_negative <= 1'b0;
      rsp_div_zero    <= 1'b0;
      rsp_overflow    <= 1'b0;
      div_a           <= '0;
      div_b           <= '0;
      div_go          <= 1'b0;
      neg_a           <= 1'b0;
      neg_b           <= 1'b0;
      ovf             <= 1'b0;
      mag_a           <= '0;
      mag_b           <= '0;
      q_hi            <= '0;
      q_mag           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            neg_a     <= in_neg_a;
            neg_b     <= in_neg_b;
            mag_a     <= in_neg_a ? (32'd0 - req_a) : req_a;
            mag_b     <= in_neg_b ? (32'd0 - req_b) : req_b;
            ovf       <= req_signed && (req_a == INT_MIN) && (req_b == 32'hFFFF_FFFF);
            req_ready <= 1'b0;
            state     <= PREP;
          end
        end
        PREP: begin
          // lz[5] is set only for a zero divisor.
          if (lz[5]) begin
            rsp_q           <= ZERO_RESULT;
            rsp_is_zero     <= (ZERO_RESULT == 32'd0);
            rsp_is_negative <= ZERO_RESULT[31];
            rsp_div_zero    <= 1'b1;
            rsp_overflow    <= 1'b0;
            rsp_valid       <= 1'b1;
            state           <= DONE;
          end else if (mag_b[31]) begin
            q_mag <= {31'd0, (mag_a >= mag_b)};
            state <= FIX;
          end else begin
            if (mag_a[31]) begin
              if (t_full <= mag_a) begin
                div_a <= mag_a - t_full;
                q_hi  <= q_hi_full;
              end else begin
                div_a <= mag_a - t_half;
                q_hi  <= q_hi_half;
              end
            end else begin
              div_a <= mag_a;
              q_hi  <= '0;
            end
            div_b  <= mag_b;
            div_go <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          div_go <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (div_available) begin
            q_mag <= q_hi | div_c;
            state <= FIX;
          end
        end
        FIX: begin
          rsp_q           <= fix_q;
          rsp_is_zero     <= (fix_q == 32'd0);
          rsp_is_negative <= fix_q[31];
          rsp_div_zero    <= 1'b0;
          rsp_overflow    <= ovf;
          rsp_valid       <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_stage.md
Name: div_stage

Overview:
- Request/response front-end for the 32-bit unsigned iterative divider (`divider`).
- Accepts signed or unsigned requests and converts operands to magnitudes. Issues `go` to the divider, waits for `available`, then applies sign correction and flags.
- Two classes of operand are handled locally because the divider cannot complete them:
  - b == 0: the divider never terminates.
  - Dividend magnitude ≥ 2^31: the divisor shift overflows to 0 and the divider never terminates.
- Sits between the CPU execute stage and the divider; sole driver of the divider's a/b/go.

Parameters:
- ZERO_RESULT, 32'hFFFF_FFFF, quotient returned for division by zero.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  stage can accept; high only in IDLE
- req_a  input  32  dividend
- req_b  input  32  divisor
- req_signed  input  1  1 = two's-complement operands
- rsp_valid  output  1  result valid; held until accepted
- rsp_ready  input  1  consumer accepts result
- rsp_q  output  32  quotient, truncated toward zero
- rsp_is_zero  output  1  rsp_q == 0
- rsp_is_negative  output  1  rsp_q[31]
- rsp_div_zero  output  1  b was 0
- rsp_overflow  output  1  signed 0x80000000 / 0xFFFFFFFF
- div_a  output  32  to divider a
- div_b  output  32  to divider b
- div_go  output  1  to divider go; one-cycle pulse
- div_c  input  32  from divider c
- div_available  input  1  from divider; one-cycle pulse

Behaviour:
- Reset (async, active-low):
  - State = IDLE.
  - All outputs 0 except req_ready = 1.
  - Internal operand and partial-quotient registers = 0.
- State machine:
  - IDLE:
    - On req_valid && req_ready: latch operands.
    - neg_a = signed & a[31]; neg_b = signed & b[31].
    - mag_a = neg_a ? -a : a; mag_b likewise.
    - Go to PREP.
  - PREP (one cycle):
    - If mag_b == 0: q = ZERO_RESULT, div_zero = 1, no sign fix. Go to DONE.
    - Else if mag_b[31]: q_mag = (mag_a >= mag_b), 0 or 1. Go to FIX.
    - Else if mag_a[31] (split path):
      - k = leading-zero count of mag_b (k ≥ 1); t = mag_b << k.
      - If t <= mag_a: a' = mag_a − t, q_hi = 1 << k.
      - Else: a' = mag_a − (t >> 1), q_hi = 1 << (k−1).
      - a' < 2^31 is guaranteed. Go to ISSUE with dividend a'.
    - Else: a' = mag_a, q_hi = 0. Go to ISSUE.
  - ISSUE: div_a = a', div_b = mag_b, div_go = 1 for exactly one cycle. Go to WAIT.
  - WAIT:
    - div_go = 0.
    - div_available is ignored in every state except WAIT.
    - On div_available: q_mag = q_hi | div_c (no overlapping bits). Go to FIX.
  - FIX:
    - q = (neg_a ^ neg_b) ? −q_mag : q_mag.
    - overflow = signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF; result then 32'h8000_0000.
    - Go to DONE.
  - DONE:
    - rsp_valid = 1; rsp_q and flags registered and stable.
    - On rsp_ready: rsp_valid drops, go to IDLE.
- Divider contract:
  - div_a and div_b are held stable from ISSUE through WAIT.
  - div_go is never asserted outside ISSUE.
  - A new go restarts the divider from any internal step.
- Latency, accept edge to rsp_valid:
  - Divider path: 4 cycles + divider time.
  - b == 0: 2 cycles.
  - mag_b[31] path: 3 cycles.
- Reset mid-operation: returns to IDLE immediately; any in-flight divider result is discarded; no response emitted.
- Back-to-back: the next request is accepted only from IDLE, i.e. the cycle after the response handshake.
- Flag ownership: rsp_is_zero and rsp_is_negative are derived from rsp_q here; the divider's flags are unused.

Decomposition:
- Package div_pkg holds:
  - state encoding constants: IDLE, PREP, ISSUE, WAIT, FIX, DONE;
  - ZERO_RESULT default;
  - INT_MIN constant 32'h8000_0000.
- One natural sub-module: lzc32, a combinational 32-bit leading-zero counter used in PREP.

Test Plan:
- Unsigned 100 / 7 → rsp_q = 14, all flags 0; exactly one div_go pulse; div_a = 100, div_b = 7.
- Signed −100 / 7 (0xFFFFFF9C, 7) → rsp_q = 0xFFFFFFF2, rsp_is_negative = 1.
- Unsigned 0xFFFFFFFF / 1 → split path: div_a = 0x7FFFFFFF; rsp_q = 0xFFFFFFFF; completes without hang.
- Signed 0x80000000 / 0xFFFFFFFF → rsp_q = 0x80000000, rsp_overflow = 1.
- Unsigned 5 / 0 → rsp_q = 0xFFFFFFFF, rsp_div_zero = 1, div_go never asserted, rsp_valid 2 cycles after accept.
- Hold rsp_ready = 0 for 10 cycles with rsp_valid high → outputs stable and req_ready = 0. Then pull reset low during WAIT of a new request → rsp_valid = 0 and req_ready = 1, with no response after release.
